dmem_resp: RTL and testbench

- Data-memory responder: the memory-side end of the pipeMA memory-access request interface.
- Accepts one byte/half/word read or write per four-phase handshake and serves it from an internal little-endian byte array after a parameterised wait-state count.
- Returns read data or commits write data, then completes with ack/err.
- Sits between pipeMA and the system bus; replaces the behavioural memory model in simulation and synthesises as a RAM.

---
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_resp.sv | 165 ++++++++++++++++
 tb/tb_dmem_resp.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the pipeMA memory-access stage (master)
// and the data-memory responder (slave).
interface dmem_if #(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
);
  logic               co_re;
  logic               co_we;
  logic [1:0]         co_rlen;
  logic [1:0]         co_wlen;
  logic [MADDR_L-1:0] m_raddr;
  logic [MADDR_L-1:0] m_waddr;
  logic [DATA_L-1:0]  mem_out;
  logic [DATA_L-1:0]  mem_in;
  logic               ack;
  logic               err;
  logic               busy;

  modport master (
    output co_re, co_we, co_rlen, co_wlen, m_raddr, m_waddr, mem_out,
    input  mem_in, ack, err, busy
  );

  modport slave (
    input  co_re, co_we, co_rlen, co_wlen, m_raddr, m_waddr, mem_out,
    output mem_in, ack, err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: serves byte/half/word reads and writes from a
// little-endian byte array after LAT wait states, completing with ack/err.
module dmem_resp #(
  parameter int MADDR_L   = 32,
  parameter int DATA_L    = 32,
  parameter int MEM_BYTES = 4096,
  parameter int LAT       = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  // Four-phase handshake: the master raises co_re or co_we (level) and holds it
  // with stable fields until ack=1; the slave samples once in IDLE, holds ack
  // (and err) until both requests are low at an edge, then drops ack and
  // returns to IDLE. Request inputs are ignored between sampling and IDLE.

  localparam int IDX_W = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  logic [7:0] mem [MEM_BYTES];

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic               is_wr, is_wr_n;
  logic               fault_q, fault_n;
  logic [1:0]         len_q, len_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [DATA_L-1:0]  wdata_q, wdata_n;
  logic               ack_q, ack_n;
  logic               err_q, err_n;
  logic [DATA_L-1:0]  rdata_q, rdata_n;
  logic               mem_wr_en;

  logic [1:0]         sel_len;
  logic [MADDR_L-1:0] sel_addr;
  logic               req_fault;
  logic [7:0]         rd_b [4];
  logic [DATA_L-1:0]  rd_word;
  logic [3:0]         lane_en;
  logic               unused_addr_hi;

  // A lone write uses the write fields; anything else uses the read fields.
  always_comb begin
    sel_len   = (bus.co_we && !bus.co_re) ? bus.co_wlen : bus.co_rlen;
    sel_addr  = (bus.co_we && !bus.co_re) ? bus.m_waddr : bus.m_raddr;
    req_fault = (bus.co_re && bus.co_we)
             || (sel_len == 2'd3)
             || (sel_len == 2'd1 && sel_addr[0])
             || (sel_len == 2'd2 && sel_addr[1:0] != 2'b00);
  end

  assign unused_addr_hi = ^sel_addr[MADDR_L-1:IDX_W];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_b[i] = mem[idx_q + IDX_W'(i)];
    end
    case (len_q)
      2'd0:    rd_word = {24'd0, rd_b[0]};
      2'd1:    rd_word = {16'd0, rd_b[1], rd_b[0]};
      default: rd_word = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
    endcase
    lane_en = {len_q == 2'd2, len_q == 2'd2, len_q != 2'd0, 1'b1};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    is_wr_n   = is_wr;
    fault_n   = fault_q;
    len_n     = len_q;
    idx_n     = idx_q;
    wdata_n   = wdata_q;
    ack_n     = ack_q;
    err_n     = err_q;
    rdata_n   = rdata_q;
    mem_wr_en = 1'b0;
    case (state)
      IDLE: begin
        if (bus.co_re || bus.co_we) begin
          state_n = WAIT;
          cnt_n   = 4'(LAT);
          is_wr_n = bus.co_we;
          fault_n = req_fault;
          len_n   = sel_len;
          idx_n   = sel_addr[IDX_W-1:0];
          wdata_n = bus.mem_out;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n   = ACK;
          ack_n     = 1'b1;
          err_n     = fault_q;
          mem_wr_en = is_wr && !fault_q;
          if (fault_q) begin
            rdata_n = '0;
          end else if (!is_wr) begin
            rdata_n = rd_word;
          end
        end
      end
      ACK: begin
        if (!bus.co_re && !bus.co_we) begin
          state_n = IDLE;
          ack_n   = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      is_wr   <= 1'b0;
      fault_q <= 1'b0;
      len_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      is_wr   <= is_wr_n;
      fault_q <= fault_n;
      len_q   <= len_n;
      idx_q   <= idx_n;
      wdata_q <= wdata_n;
      ack_q   <= ack_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
    end
  end

  // Array has no reset; gating with rst keeps a write aborted by reset uncommitted.
  always_ff @(posedge clk) begin
    if (mem_wr_en && rst) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[idx_q + IDX_W'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_in = rdata_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state != IDLE);
  assign dbg_state  = state;
endmodule

// File: tb/tb_dmem_resp.sv
// Randomised scoreboard bench for dmem_resp against a byte-array reference model.
module tb_dmem_resp;
  localparam int LAT       = 2;
  localparam int MEM_BYTES = 4096;
  localparam int ACK_LIMIT = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.MADDR_L(32), .DATA_L(32)) bus ();
  logic [1:0] dbg_state;

  dmem_resp #(
    .MADDR_L(32), .DATA_L(32), .MEM_BYTES(MEM_BYTES), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard state: {err, mem_in} per transaction
  logic [32:0] exp_q[$];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] model_mem_in = 32'd0;
  logic [32:0] mon_e;
  logic        ack_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] len);
    logic [31:0] v;
    int n;
    n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      v = v | ({24'd0, ref_mem[(a + 32'(i)) % MEM_BYTES]} << (8 * i));
    end
    return v;
  endfunction

  function automatic bit model_fault(input bit re, input bit we, input logic [1:0] len,
                                     input logic [31:0] a);
    if (re && we) return 1'b1;
    if (len == 2'd3) return 1'b1;
    if (len == 2'd1 && (a % 2) != 0) return 1'b1;
    if (len == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // monitor: pop one expectation at every rising ack
  always @(negedge clk) begin
    if (rst && bus.ack && !ack_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", {31'd0, bus.err}, {31'd0, mon_e[32]});
        check("resp_data", bus.mem_in, mon_e[31:0]);
      end
    end
    ack_d = rst ? bus.ack : 1'b0;
  end

  // driver: one full four-phase transaction, holding the request 'hold' edges after ack
  task automatic req(input bit re, input bit we, input logic [1:0] len,
                     input logic [31:0] addr, input logic [31:0] data, input int hold);
    bit f;
    int k;
    bit got;
    f = model_fault(re, we, len, addr);
    if (f) begin
      model_mem_in = 32'd0;
    end else if (re) begin
      model_mem_in = model_read(addr, len);
    end else begin
      for (int i = 0; i < ((len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4); i++)
        ref_mem[(addr + 32'(i)) % MEM_BYTES] = data[8*i +: 8];
    end
    exp_q.push_back({f, model_mem_in});

    @(negedge clk);
    bus.co_re   = re;
    bus.co_we   = we;
    bus.co_rlen = re ? len : 2'($urandom_range(0, 3));
    bus.co_wlen = we ? len : 2'($urandom_range(0, 3));
    bus.m_raddr = re ? addr : $urandom;
    bus.m_waddr = we ? addr : $urandom;
    bus.mem_out = we ? data : $urandom;

    k = 0;
    got = 1'b0;
    while (k < ACK_LIMIT && !got) begin
      @(posedge clk); #1;
      k++;
      got = bus.ack;
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      check("ack_latency", 32'(k), 32'(LAT + 2));
      check("busy_in_ack", {31'd0, bus.busy}, 32'd1);
      for (int h = 0; h < hold; h++) begin
        bus.m_raddr = $urandom;
        bus.m_waddr = $urandom;
        @(posedge clk); #1;
        check("ack_hold", {31'd0, bus.ack}, 32'd1);
        check("hold_data", bus.mem_in, model_mem_in);
      end
    end
    @(negedge clk);
    bus.co_re = 1'b0;
    bus.co_we = 1'b0;
    @(posedge clk); #1;
    check("ack_fall", {31'd0, bus.ack}, 32'd0);
    check("err_fall", {31'd0, bus.err}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    check("data_keep", bus.mem_in, model_mem_in);
  endtask

  // write 0x12345678 to 0x200 and reset on the edge where the commit would happen
  task automatic reset_mid_wait();
    @(negedge clk);
    bus.co_we   = 1'b1;
    bus.co_wlen = 2'd2;
    bus.m_waddr = 32'h200;
    bus.mem_out = 32'h1234_5678;
    @(posedge clk); #1;
    check("wait_busy", {31'd0, bus.busy}, 32'd1);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.co_we = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", {31'd0, bus.ack}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_data", bus.mem_in, 32'd0);
    model_mem_in = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("abort_idle_ack", {31'd0, bus.ack}, 32'd0);
  endtask

  initial begin
    bit re, we;
    int op;
    logic [1:0] len;
    logic [31:0] off;

    bus.co_re   = 1'b1;
    bus.co_we   = 1'b0;
    bus.co_rlen = 2'd2;
    bus.co_wlen = 2'd0;
    bus.m_raddr = 32'h0;
    bus.m_waddr = 32'h0;
    bus.mem_out = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

    // reset held with a pending read request
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      check("rst_ack", {31'd0, bus.ack}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      check("rst_data", bus.mem_in, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
    end
    @(negedge clk);
    bus.co_re = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // directed
    req(0, 1, 2'd2, 32'h200, 32'h0000_0000, 0);
    req(0, 1, 2'd2, 32'h100, 32'hDEAD_BEEF, 0);
    req(1, 0, 2'd2, 32'h100, 32'h0, 0);
    req(0, 1, 2'd0, 32'h101, 32'h0000_0055, 0);
    req(1, 0, 2'd1, 32'h100, 32'h0, 0);
    req(1, 0, 2'd0, 32'h103, 32'h0, 0);
    req(1, 0, 2'd1, 32'h101, 32'h0, 0);
    req(0, 1, 2'd2, 32'h102, 32'hFFFF_FFFF, 0);
    req(1, 0, 2'd2, 32'h100, 32'h0, 0);
    req(1, 1, 2'd2, 32'h100, 32'h1111_1111, 0);
    req(1, 0, 2'd3, 32'h100, 32'h0, 0);
    req(0, 1, 2'd3, 32'h104, 32'h2222_2222, 0);
    req(1, 0, 2'd2, 32'h100, 32'h0, 5);
    reset_mid_wait();
    req(1, 0, 2'd2, 32'h200, 32'h0, 0);
    req(0, 1, 2'd0, 32'(MEM_BYTES + 4), 32'h0000_00AA, 0);
    req(1, 0, 2'd0, 32'h4, 32'h0, 0);

    // random traffic in an initialised window, with aliasing upper bits
    for (int i = 0; i < 16; i++) req(0, 1, 2'd2, 32'h300 + 32'(4 * i), $urandom, 0);
    for (int t = 0; t < 80; t++) begin
      op  = $urandom_range(0, 9);
      re  = (op <= 3) || (op == 8) || (op == 9 && $urandom_range(0, 1) == 0);
      we  = !re || (op == 8);
      len = (op == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      off = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (len == 2'd1) off = off & ~32'd1;
        if (len == 2'd2) off = off & ~32'd3;
      end
      req(re, we, len, 32'h300 + off + 32'($urandom_range(0, 3) * MEM_BYTES),
          $urandom, $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    #1 check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
